// File: rtl/uart_receiver_fsm.sv
// uart_receiver_fsm
//   UART receive path. The serial line is oversampled on UCLK, and a start
//   bit is qualified at its mid-point. Data bits are sampled at mid-bit and
//   shifted in LSB-first. Optional parity and the stop bit are then checked.
//   Each frame ends in exactly one registered one-cycle pulse: data_valid,
//   parity_error or framing_error.
//
// Ports
//   UCLK          in   receiver clock, OVERSAMPLE x baud rate
//   reset         in   asynchronous, active-high reset
//   rx_in         in   raw serial line, idle level 1
//   parity_enable in   frame carries a parity bit (captured at frame start)
//   parity_type   in   0 = even, 1 = odd (captured at frame start)
//   rx_data       out  last good byte, LSB = first received bit
//   data_valid    out  one-cycle pulse, rx_data updated with a good frame
//   parity_error  out  one-cycle pulse, parity mismatch
//   framing_error out  one-cycle pulse, stop bit sampled 0
//   busy          out  high in every state except IDLE
module uart_receiver_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH) + 1;

  // Sample point inside a bit, and the last oversample tick of a bit.
  localparam logic [SW-1:0] MID      = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST     = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                  state;
  logic                    sync1;
  logic                    rx_s;
  logic [SW-1:0]           sample_cnt;
  logic [SW-1:0]           sample_next;
  logic [BW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    xor_data;
  logic                    par_en;
  logic                    par_type;
  logic                    par_err;

  // Two-flop synchroniser on the asynchronous serial line.
  // NOTE: both flops reset to the idle level 1. A reset value of 0 would look
  // like a start bit on the first cycle after reset.
  always_ff @(posedge UCLK or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
    end
  end

  // The oversample counter wraps explicitly, because OVERSAMPLE need not be
  // a power of two.
  always_comb begin
    sample_next = sample_cnt + SW'(1);
    if (sample_cnt == LAST) sample_next = '0;
  end

  assign busy = (state != IDLE);

  // NOTE: every register in this block uses non-blocking assignment, so all
  // decisions in one cycle see the values from the start of that cycle.
  always_ff @(posedge UCLK or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      sample_cnt    <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      xor_data      <= 1'b0;
      par_en        <= 1'b0;
      par_type      <= 1'b0;
      par_err       <= 1'b0;
      rx_data       <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      // The status outputs are pulses. They are high only in the cycle after
      // the stop-bit evaluation.
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state      <= START;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            xor_data   <= 1'b0;
            par_err    <= 1'b0;
            // Frame format is frozen here, so it cannot change mid-frame.
            par_en     <= parity_enable;
            par_type   <= parity_type;
          end
        end

        START: begin
          sample_cnt <= sample_next;
          if (sample_cnt == MID && rx_s) begin
            state <= IDLE;  // line went high again before mid-bit: glitch
          end else if (sample_cnt == LAST) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end

        DATA: begin
          sample_cnt <= sample_next;
          if (sample_cnt == MID) begin
            shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
            xor_data  <= xor_data ^ rx_s;
          end
          if (sample_cnt == LAST) begin
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) state <= par_en ? PARITY : STOP;
          end
        end

        PARITY: begin
          sample_cnt <= sample_next;
          if (sample_cnt == MID) par_err <= ((xor_data ^ rx_s) != par_type);
          if (sample_cnt == LAST) state <= STOP;
        end

        STOP: begin
          sample_cnt <= sample_next;
          // Leaving at mid-stop leaves half a bit of margin, so the FSM can
          // catch a start bit that follows a single stop bit directly.
          if (sample_cnt == MID) begin
            state <= IDLE;
            if (!rx_s) begin
              framing_error <= 1'b1;
            end else if (par_err) begin
              parity_error <= 1'b1;
            end else begin
              rx_data    <= shift_reg;
              data_valid <= 1'b1;
            end
          end
        end

        default: begin
          state      <= IDLE;
          sample_cnt <= '0;
        end
      endcase
    end
  end

endmodule
